cc_monitor_multi: RTL and testbench

//  Parametrised N-channel MPEG-2 TS continuity-counter monitor (TR 101 290 CC_error / PID_error).
//  Per channel: parses the 4-byte TS header of a byte stream and tracks the expected CC of one configured PID.

---
 rtl/mpeg2ts_pkg.sv | 25 ++
 rtl/cc_channel.sv | 163 ++++++++++++++++
 rtl/cc_monitor_multi.sv | 44 ++++
 tb/tb_cc_monitor_multi.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpeg2ts_pkg.sv
// Shared MPEG-2 transport stream constants and the header-parser state type
// used by the continuity-counter monitor.
package mpeg2ts_pkg;
    localparam logic [7:0]  SYNC_BYTE   = 8'h47;
    localparam int          PKT_LEN     = 188;
    localparam logic [12:0] NULL_PID    = 13'h1FFF;

    localparam logic [1:0]  AFC_RSVD    = 2'b00;
    localparam logic [1:0]  AFC_PAYLOAD = 2'b01;
    localparam logic [1:0]  AFC_ADAPT   = 2'b10;
    localparam logic [1:0]  AFC_BOTH    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B2,
        ST_B3,
        ST_B4,
        ST_PAYLOAD
    } hdr_state_e;

    // Codes 01 and 11 carry a payload; only those advance the continuity counter.
    function automatic logic afc_has_payload(input logic [1:0] afc);
        return afc[0];
    endfunction
endpackage

// File: rtl/cc_channel.sv
// One TS channel: header parser, continuity-counter checker, PID timeout
// tracker and saturating error counter.
module cc_channel
    import mpeg2ts_pkg::*;
#(
    parameter int                 TIMER_W = 16,
    parameter logic [TIMER_W-1:0] TIMEOUT = 500,
    parameter int                 CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         r_data,
    input  logic               r_valid,
    input  logic               sync,
    input  logic [TIMER_W-1:0] timer_in,
    input  logic [12:0]        pid_cfg,
    input  logic               err_clr,
    output logic [3:0]         cc_expected,
    output logic               cc_err,
    output logic [CNT_W-1:0]   cc_err_cnt,
    output logic               pid_timeout
);
    localparam logic [7:0] LAST_BYTE = 8'(PKT_LEN);

    hdr_state_e         state_q, state_d;
    logic [7:0]         byte_cnt_q, byte_cnt_d;
    logic               tei_q, tei_d;
    logic [4:0]         pid_hi_q, pid_hi_d;
    logic [7:0]         pid_lo_q, pid_lo_d;
    logic [12:0]        pid_cfg_q;
    logic               locked_q, locked_d;
    logic               dup_seen_q, dup_seen_d;
    logic [3:0]         last_cc_q, last_cc_d;
    logic [3:0]         cc_exp_q, cc_exp_d;
    logic               cc_err_q, cc_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TIMER_W-1:0] last_ts_q, last_ts_d;

    logic               is_sync, cfg_changed, check;
    logic [12:0]        hdr_pid;
    logic [3:0]         cc_in;
    logic [1:0]         afc_in;
    logic [TIMER_W-1:0] elapsed;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign is_sync     = r_valid & sync & (r_data == SYNC_BYTE);
    assign cfg_changed = (pid_cfg != pid_cfg_q);
    assign hdr_pid     = {pid_hi_q, pid_lo_q};
    assign cc_in       = r_data[3:0];
    assign afc_in      = r_data[5:4];
    assign check       = r_valid & ~is_sync & (state_q == ST_B4) & (hdr_pid == pid_cfg)
                       & (hdr_pid != NULL_PID) & ~tei_q;
    assign elapsed     = timer_in - last_ts_q;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        tei_d      = tei_q;
        pid_hi_d   = pid_hi_q;
        pid_lo_d   = pid_lo_q;
        locked_d   = locked_q;
        dup_seen_d = dup_seen_q;
        last_cc_d  = last_cc_q;
        cc_exp_d   = cc_exp_q;
        last_ts_d  = last_ts_q;
        cc_err_d   = 1'b0;

        // A qualified sync byte always starts a fresh header, dropping any partial packet.
        if (r_valid) begin
            if (is_sync) begin
                state_d = ST_B2;
            end else begin
                case (state_q)
                    ST_B2: begin
                        tei_d    = r_data[7];
                        pid_hi_d = r_data[4:0];
                        state_d  = ST_B3;
                    end
                    ST_B3: begin
                        pid_lo_d = r_data;
                        state_d  = ST_B4;
                    end
                    ST_B4: begin
                        byte_cnt_d = 8'd5;
                        state_d    = ST_PAYLOAD;
                    end
                    ST_PAYLOAD: begin
                        if (byte_cnt_q == LAST_BYTE) state_d = ST_IDLE;
                        else                         byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                    default: state_d = state_q;
                endcase
            end
        end

        if (cfg_changed) begin
            locked_d   = 1'b0;
            dup_seen_d = 1'b0;
        end else if (check) begin
            if (afc_has_payload(afc_in)) last_ts_d = timer_in;
            if (!locked_q) begin
                locked_d   = 1'b1;
                dup_seen_d = 1'b0;
                last_cc_d  = cc_in;
            end else if (afc_has_payload(afc_in)) begin
                if (cc_in == 4'(last_cc_q + 4'd1)) begin
                    last_cc_d  = cc_in;
                    dup_seen_d = 1'b0;
                end else if (cc_in == last_cc_q && !dup_seen_q) begin
                    dup_seen_d = 1'b1;
                end else begin
                    cc_err_d   = 1'b1;
                    last_cc_d  = cc_in;
                    dup_seen_d = 1'b0;
                end
            end else if (cc_in != last_cc_q) begin
                cc_err_d   = 1'b1;
                last_cc_d  = cc_in;
                dup_seen_d = 1'b0;
            end
            cc_exp_d = 4'(last_cc_d + 4'd1);
        end

        // Clear has priority, but an error in the same cycle still counts once.
        if (err_clr)       cnt_d = {{(CNT_W-1){1'b0}}, cc_err_d};
        else if (cc_err_d) cnt_d = sat_inc(cnt_q);
        else               cnt_d = cnt_q;
    end

    always_ff @(posedge clk) begin
        byte_cnt_q <= byte_cnt_d;
        tei_q      <= tei_d;
        pid_hi_q   <= pid_hi_d;
        pid_lo_q   <= pid_lo_d;
        pid_cfg_q  <= pid_cfg;
        last_cc_q  <= last_cc_d;
        if (rst) begin
            state_q    <= ST_IDLE;
            locked_q   <= 1'b0;
            dup_seen_q <= 1'b0;
            cc_exp_q   <= 4'd0;
            cc_err_q   <= 1'b0;
            cnt_q      <= '0;
            last_ts_q  <= timer_in;
        end else begin
            state_q    <= state_d;
            locked_q   <= locked_d;
            dup_seen_q <= dup_seen_d;
            cc_exp_q   <= cc_exp_d;
            cc_err_q   <= cc_err_d;
            cnt_q      <= cnt_d;
            last_ts_q  <= last_ts_d;
        end
    end

    assign cc_expected = cc_exp_q;
    assign cc_err      = cc_err_q;
    assign cc_err_cnt  = cnt_q;
    assign pid_timeout = locked_q & (elapsed >= TIMEOUT);
endmodule

// File: rtl/cc_monitor_multi.sv
// N-channel MPEG-2 TS continuity-counter monitor: one independent cc_channel
// per aligned byte stream, with the packed buses sliced per channel.
module cc_monitor_multi
    import mpeg2ts_pkg::*;
#(
    parameter int                 N_CH    = 4,
    parameter int                 TIMER_W = 16,
    parameter logic [TIMER_W-1:0] TIMEOUT = 16'd500,
    parameter int                 CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*N_CH-1:0]     r_data,
    input  logic [N_CH-1:0]       r_valid,
    input  logic [N_CH-1:0]       sync,
    input  logic [TIMER_W-1:0]    timer_in,
    input  logic [13*N_CH-1:0]    pid_cfg,
    input  logic [N_CH-1:0]       err_clr,
    output logic [4*N_CH-1:0]     cc_expected,
    output logic [N_CH-1:0]       cc_err,
    output logic [CNT_W*N_CH-1:0] cc_err_cnt,
    output logic [N_CH-1:0]       pid_timeout
);
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        cc_channel #(
            .TIMER_W (TIMER_W),
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .r_data      (r_data[8*k +: 8]),
            .r_valid     (r_valid[k]),
            .sync        (sync[k]),
            .timer_in    (timer_in),
            .pid_cfg     (pid_cfg[13*k +: 13]),
            .err_clr     (err_clr[k]),
            .cc_expected (cc_expected[4*k +: 4]),
            .cc_err      (cc_err[k]),
            .cc_err_cnt  (cc_err_cnt[CNT_W*k +: CNT_W]),
            .pid_timeout (pid_timeout[k])
        );
    end
endmodule

// File: tb/tb_cc_monitor_multi.sv
// Bench for cc_monitor_multi: packet-level reference model, directed table,
// hand-written corner sequences and a randomized multi-channel phase.
module tb_cc_monitor_multi;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] r_data;
    logic [3:0]  r_valid, sync, err_clr;
    logic [15:0] timer_in;
    logic [51:0] pid_cfg;
    logic [15:0] cc_expected;
    logic [3:0]  cc_err, pid_timeout;
    logic [63:0] cc_err_cnt;

    always #5 clk = ~clk;

    cc_monitor_multi #(.N_CH(4), .TIMER_W(16), .TIMEOUT(16'd500), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .r_data(r_data), .r_valid(r_valid), .sync(sync),
        .timer_in(timer_in), .pid_cfg(pid_cfg), .err_clr(err_clr),
        .cc_expected(cc_expected), .cc_err(cc_err), .cc_err_cnt(cc_err_cnt),
        .pid_timeout(pid_timeout)
    );

    typedef struct {
        logic [1:0]  afc;
        logic [12:0] pid;
        logic        tei;
        logic [3:0]  cc;
        logic        err;
        logic [3:0]  exp_cc;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl[36];

    logic [7:0]  d_byte[N];
    logic [3:0]  b4_mask, clr_b4;
    logic        hdr_tei[N];
    logic [12:0] hdr_pid[N];
    logic [1:0]  hdr_afc[N];
    logic [3:0]  hdr_cc[N];
    int          tinc;
    bit          rnd_mode;

    bit          m_locked[N], m_dup[N], m_err[N];
    int          m_last[N], m_exp[N], m_cnt[N], m_ts[N];
    logic [12:0] m_cfg[N];

    logic [3:0]  cap_err, cap_tmo, cap_exp0;
    logic [15:0] cap_cnt0;
    int          n_cmp, n_bad;

    function automatic vec_t mk(logic [1:0] afc, logic [12:0] pid, logic tei, logic [3:0] cc,
                                logic err, logic [3:0] e, logic [15:0] cnt);
        vec_t v;
        v.afc = afc; v.pid = pid; v.tei = tei; v.cc = cc; v.err = err; v.exp_cc = e; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Packet-level rules applied at the clock edge that consumes the fourth header byte.
    function automatic void model_step();
        for (int ch = 0; ch < N; ch++) begin
            logic [12:0] cfg;
            int cc;
            bit pay;
            cfg = pid_cfg[13*ch +: 13];
            if (rst) begin
                m_locked[ch] = 0; m_dup[ch] = 0; m_err[ch] = 0;
                m_last[ch] = 0; m_exp[ch] = 0; m_cnt[ch] = 0;
                m_ts[ch] = int'(timer_in); m_cfg[ch] = cfg;
                continue;
            end
            m_err[ch] = 0;
            if (cfg != m_cfg[ch]) begin
                m_locked[ch] = 0; m_dup[ch] = 0;
            end else if (b4_mask[ch] && hdr_pid[ch] == cfg && cfg != 13'h1FFF && !hdr_tei[ch]) begin
                cc  = int'(hdr_cc[ch]);
                pay = hdr_afc[ch][0];
                if (pay) m_ts[ch] = int'(timer_in);
                if (!m_locked[ch]) begin
                    m_locked[ch] = 1; m_dup[ch] = 0; m_last[ch] = cc;
                end else if (pay) begin
                    if (cc == (m_last[ch] + 1) % 16) begin m_last[ch] = cc; m_dup[ch] = 0; end
                    else if (cc == m_last[ch] && !m_dup[ch]) m_dup[ch] = 1;
                    else begin m_err[ch] = 1; m_last[ch] = cc; m_dup[ch] = 0; end
                end else if (cc != m_last[ch]) begin
                    m_err[ch] = 1; m_last[ch] = cc; m_dup[ch] = 0;
                end
                m_exp[ch] = (m_last[ch] + 1) % 16;
            end
            m_cfg[ch] = cfg;
            if (err_clr[ch]) m_cnt[ch] = int'(m_err[ch]);
            else if (m_err[ch] && m_cnt[ch] < 65535) m_cnt[ch]++;
        end
    endfunction

    task automatic cycle();
        logic [3:0]  e_err, e_tmo;
        logic [15:0] e_exp, el;
        logic [63:0] e_cnt;
        for (int ch = 0; ch < N; ch++) begin
            r_data[8*ch +: 8] = d_byte[ch];
            err_clr[ch] = (rnd_mode && $urandom_range(15) == 0) || (b4_mask[ch] && clr_b4[ch]);
        end
        @(posedge clk);
        model_step();
        #1;
        for (int ch = 0; ch < N; ch++) begin
            el = timer_in - 16'(m_ts[ch]);
            e_err[ch]          = m_err[ch];
            e_tmo[ch]          = m_locked[ch] && (el >= 16'd500);
            e_exp[4*ch +: 4]   = 4'(m_exp[ch]);
            e_cnt[16*ch +: 16] = 16'(m_cnt[ch]);
        end
        check("cc_err", cc_err, e_err);
        check("cc_expected", cc_expected, e_exp);
        check("cc_err_cnt", cc_err_cnt, e_cnt);
        check("pid_timeout", pid_timeout, e_tmo);
        if (b4_mask != 4'd0) begin
            cap_err = cc_err; cap_tmo = pid_timeout;
            cap_exp0 = cc_expected[3:0]; cap_cnt0 = cc_err_cnt[15:0];
        end
        timer_in = timer_in + 16'(tinc);
    endtask

    task automatic idle_cycle();
        r_valid = 4'd0; b4_mask = 4'd0;
        for (int ch = 0; ch < N; ch++) begin
            d_byte[ch] = ($urandom_range(1) == 0) ? 8'h47 : 8'($urandom);
            sync[ch]   = 1'($urandom_range(1));
        end
        cycle();
    endtask

    task automatic send_pkt(int plen, bit stalls);
        for (int k = 0; k < 4; k++) begin
            if (stalls) while ($urandom_range(3) == 0) idle_cycle();
            for (int ch = 0; ch < N; ch++) begin
                case (k)
                    0: d_byte[ch] = 8'h47;
                    1: d_byte[ch] = {hdr_tei[ch], 2'($urandom), hdr_pid[ch][12:8]};
                    2: d_byte[ch] = hdr_pid[ch][7:0];
                    default: d_byte[ch] = {2'($urandom), hdr_afc[ch], hdr_cc[ch]};
                endcase
                sync[ch] = (k == 0) ? 1'b1 : (1'($urandom_range(1)) && d_byte[ch] != 8'h47);
            end
            r_valid = 4'hF;
            b4_mask = (k == 3) ? 4'hF : 4'd0;
            cycle();
        end
        b4_mask = 4'd0;
        for (int p = 0; p < plen; p++) begin
            for (int ch = 0; ch < N; ch++) begin
                d_byte[ch]  = 8'($urandom);
                sync[ch]    = 1'($urandom_range(1));
                r_valid[ch] = ($urandom_range(7) != 0);
                if (sync[ch] && d_byte[ch] == 8'h47) d_byte[ch] = 8'h46;
            end
            cycle();
        end
    endtask

    task automatic set_hdr_all(logic [1:0] afc, logic [12:0] pid, logic tei, logic [3:0] cc);
        for (int ch = 0; ch < N; ch++) begin
            hdr_afc[ch] = afc; hdr_pid[ch] = pid; hdr_tei[ch] = tei; hdr_cc[ch] = cc;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = mk(2'b01, 13'h100, 1'b0, 4'(i), 1'b0, 4'(i + 1), 16'd0);
        tbl[16] = mk(2'b01, 13'h100, 0, 4'd0, 0, 4'd1, 16'd0);
        tbl[17] = mk(2'b01, 13'h100, 0, 4'd1, 0, 4'd2, 16'd0);
        tbl[18] = mk(2'b01, 13'h100, 0, 4'd2, 0, 4'd3, 16'd0);
        tbl[19] = mk(2'b01, 13'h100, 0, 4'd3, 0, 4'd4, 16'd0);
        tbl[20] = mk(2'b01, 13'h100, 0, 4'd4, 0, 4'd5, 16'd0);
        tbl[21] = mk(2'b01, 13'h100, 0, 4'd4, 0, 4'd5, 16'd0);
        tbl[22] = mk(2'b01, 13'h100, 0, 4'd5, 0, 4'd6, 16'd0);
        tbl[23] = mk(2'b01, 13'h100, 0, 4'd6, 0, 4'd7, 16'd0);
        tbl[24] = mk(2'b01, 13'h100, 0, 4'd7, 0, 4'd8, 16'd0);
        tbl[25] = mk(2'b01, 13'h100, 0, 4'd7, 0, 4'd8, 16'd0);
        tbl[26] = mk(2'b01, 13'h100, 0, 4'd7, 1, 4'd8, 16'd1);
        tbl[27] = mk(2'b01, 13'h100, 0, 4'd8, 0, 4'd9, 16'd1);
        tbl[28] = mk(2'b01, 13'h100, 0, 4'd10, 1, 4'd11, 16'd2);
        tbl[29] = mk(2'b10, 13'h100, 0, 4'd10, 0, 4'd11, 16'd2);
        tbl[30] = mk(2'b00, 13'h100, 0, 4'd10, 0, 4'd11, 16'd2);
        tbl[31] = mk(2'b11, 13'h100, 0, 4'd11, 0, 4'd12, 16'd2);
        tbl[32] = mk(2'b01, 13'h1FFF, 0, 4'd0, 0, 4'd12, 16'd2);
        tbl[33] = mk(2'b01, 13'h200, 0, 4'd3, 0, 4'd12, 16'd2);
        tbl[34] = mk(2'b01, 13'h100, 1, 4'd3, 0, 4'd12, 16'd2);
        tbl[35] = mk(2'b01, 13'h100, 0, 4'd12, 0, 4'd13, 16'd2);

        n_cmp = 0; n_bad = 0; tinc = 1; rnd_mode = 0; clr_b4 = 4'd0; b4_mask = 4'd0;
        rst = 1'b1; r_valid = 4'd0; sync = 4'd0; r_data = 32'd0; err_clr = 4'd0; timer_in = 16'd1000;
        for (int ch = 0; ch < N; ch++) begin
            pid_cfg[13*ch +: 13] = 13'h100; d_byte[ch] = 8'd0;
        end
        set_hdr_all(2'b01, 13'h100, 1'b0, 4'd0);
        cycle(); cycle();
        check("rst_cc_expected", cc_expected, 16'd0);
        check("rst_cc_err", cc_err, 4'd0);
        check("rst_cnt", cc_err_cnt, 64'd0);
        check("rst_timeout", pid_timeout, 4'd0);
        rst = 1'b0;

        for (int i = 0; i < 36; i++) begin
            set_hdr_all(tbl[i].afc, tbl[i].pid, tbl[i].tei, tbl[i].cc);
            send_pkt(i % 3, bit'(i % 2));
            check($sformatf("tbl%0d_err", i), cap_err[0], tbl[i].err);
            check($sformatf("tbl%0d_exp", i), cap_exp0, tbl[i].exp_cc);
            check($sformatf("tbl%0d_cnt", i), cap_cnt0, tbl[i].cnt);
        end

        // Timeout across the timer wrap: last packet at 65300 -> timeout first at 264.
        tinc = 0; timer_in = 16'd65300;
        set_hdr_all(2'b01, 13'h100, 1'b0, 4'd13);
        send_pkt(0, 0);
        timer_in = 16'd263; idle_cycle();
        check("tmo_at_263", pid_timeout, 4'h0);
        timer_in = 16'd264; idle_cycle();
        check("tmo_at_264", pid_timeout, 4'hF);
        set_hdr_all(2'b01, 13'h100, 1'b0, 4'd14);
        send_pkt(0, 0);
        check("tmo_cleared", cap_tmo, 4'h0);
        tinc = 1;

        // Sync byte arriving mid-header restarts the parser.
        r_valid = 4'hF; sync = 4'hF;
        for (int ch = 0; ch < N; ch++) d_byte[ch] = 8'h47;
        cycle();
        sync = 4'h0;
        for (int ch = 0; ch < N; ch++) d_byte[ch] = 8'h01;
        cycle();
        set_hdr_all(2'b01, 13'h100, 1'b0, 4'd15);
        send_pkt(0, 0);
        check("restart_err", cap_err, 4'h0);
        check("restart_exp", cap_exp0, 4'd0);

        // Reset in the middle of a header; the tail bytes afterwards must be ignored.
        r_valid = 4'hF; sync = 4'hF;
        for (int ch = 0; ch < N; ch++) d_byte[ch] = 8'h47;
        cycle();
        sync = 4'h0;
        for (int ch = 0; ch < N; ch++) d_byte[ch] = 8'h01;
        cycle();
        rst = 1'b1; r_valid = 4'h0;
        cycle();
        check("rstmid_exp", cc_expected, 16'd0);
        check("rstmid_cnt", cc_err_cnt, 64'd0);
        check("rstmid_err", cc_err, 4'd0);
        check("rstmid_tmo", pid_timeout, 4'd0);
        rst = 1'b0; r_valid = 4'hF;
        for (int ch = 0; ch < N; ch++) d_byte[ch] = 8'h00;
        cycle();
        for (int ch = 0; ch < N; ch++) d_byte[ch] = 8'h15;
        cycle();
        set_hdr_all(2'b01, 13'h100, 1'b0, 4'd3);
        send_pkt(0, 0);
        check("relearn_err", cap_err, 4'h0);
        check("relearn_exp", cap_exp0, 4'd4);
        set_hdr_all(2'b01, 13'h100, 1'b0, 4'd9);
        send_pkt(0, 0);
        check("all_ch_err", cap_err, 4'hF);
        check("all_ch_cnt", cap_cnt0, 16'd1);
        clr_b4 = 4'hF;
        set_hdr_all(2'b01, 13'h100, 1'b0, 4'd0);
        send_pkt(0, 0);
        clr_b4 = 4'h0;
        check("clr_err_same_cycle", cap_err, 4'hF);
        check("clr_cnt_loads_1", cap_cnt0, 16'd1);

        // Randomized phase, independent PIDs per channel (one channel on the null PID).
        rnd_mode = 1;
        pid_cfg = {13'h1FFF, 13'h0AA, 13'h155, 13'h100};
        idle_cycle();
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(29) == 0) begin
                pid_cfg[13*$urandom_range(3) +: 13] = ($urandom_range(1) == 0) ? 13'h100 : 13'h0AB;
                idle_cycle();
            end
            tinc = ($urandom_range(9) < 2) ? $urandom_range(100) : 1;
            for (int ch = 0; ch < N; ch++) begin
                int r, rc;
                logic [12:0] cfg;
                cfg = pid_cfg[13*ch +: 13];
                r   = $urandom_range(9);
                rc  = $urandom_range(9);
                hdr_pid[ch] = (r < 7) ? cfg : (r < 8) ? (cfg ^ 13'h1) : 13'h1FFF;
                hdr_tei[ch] = ($urandom_range(7) == 0);
                hdr_afc[ch] = 2'($urandom);
                hdr_cc[ch]  = (rc < 5) ? 4'((m_last[ch] + 1) % 16) :
                              (rc < 7) ? 4'(m_last[ch]) : 4'($urandom);
            end
            send_pkt(($urandom_range(9) == 0) ? 184 + $urandom_range(3) : $urandom_range(6),
                     1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
